multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction and datapath width (32 or 64).
REQ-002 SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum number of mem_ready-low cycles before a bus-timeout trap.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 instr  in  XLEN  instruction register contents; only bits [31:0] are decoded.
REQ-007 mem_ready  in  1  memory acknowledge for the current request.
REQ-008 branch_taken  in  1  ALU compare result, valid in EXECUTE.
REQ-009 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-010 ir_load, pc_write  out  1 each  instruction-register load and PC update strobes.
REQ-011 pc_src  out  2  selects the next PC: 0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
REQ-012 alu_op  out  4  ALU operation code.
REQ-013 alu_src, mem_to_reg, reg_write  out  1 each  datapath selects and the register-file write enable.
REQ-014 trap  out  1  single-cycle pulse on an illegal opcode or a bus timeout.
REQ-015 trap_cause  out  2  trap cause: 1 = illegal opcode, 2 = timeout; held until the next trap.

Function
REQ-016 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK and TRAP.
REQ-017 FETCH SHALL assert mem_req with mem_we=0 and stay in FETCH until mem_ready=1.
REQ-018 On that FETCH cycle with mem_ready=1, ir_load SHALL be 1 and the next state SHALL be DECODE.
REQ-019 DECODE SHALL take exactly 1 cycle and decode opcode instr[6:0] to the next state.
  - Illegal opcode -> TRAP.
  - All legal opcodes -> EXECUTE.
REQ-020 EXECUTE, for OP / OP-IMM / LUI / AUIPC -> WRITEBACK.
REQ-021 EXECUTE, for LOAD / STORE -> MEM.
REQ-022 EXECUTE, for BRANCH: pc_write=branch_taken, pc_src=1, next FETCH.
REQ-023 EXECUTE, for JAL / JALR: pc_src = 1 or 2 respectively, next WRITEBACK.
REQ-024 The PC increment SHALL occur at WRITEBACK exit, or at MEM exit for STORE: pc_write=1, pc_src=0 (except the JAL/JALR target). For BRANCH, pc_write is asserted in EXECUTE only.
REQ-025 MEM SHALL hold mem_req=1, with mem_we=1 for STORE, until mem_ready=1.
  - LOAD -> WRITEBACK.
  - STORE -> FETCH.
REQ-026 WRITEBACK SHALL assert reg_write=1 for exactly 1 cycle, with mem_to_reg=1 only for LOAD, then go to FETCH.
REQ-027 alu_op SHALL be computed as follows.
  - OP: {instr[30], funct3}.
  - OP-IMM: {instr[30] when funct3=101, else 0, funct3}.
  - BRANCH: 4'b1000.
  - All others: 4'b0000.
REQ-028 alu_src SHALL be 1 for every opcode except OP and BRANCH.
REQ-029 Wait counter: a 4-bit-minimum counter SHALL count consecutive mem_ready-low cycles in FETCH or MEM and clear on mem_ready or on a state change.
REQ-030 When the wait counter reaches WAIT_LIMIT, the next state SHALL be TRAP with trap_cause=2, and mem_req SHALL drop in TRAP.
REQ-031 mem_ready=1 on the same cycle the counter reaches WAIT_LIMIT SHALL count as success; no trap is raised.
REQ-032 TRAP SHALL pulse trap for 1 cycle, force pc_write=0, then go to FETCH.
REQ-033 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-034 Minimum latency per instruction SHALL be 4 cycles for ALU ops, 5 for LOAD and 3 for a not-taken BRANCH.

Reset
REQ-035 While rst_n=0, state SHALL be FETCH, the wait counter 0, trap_cause 0, and all strobes 0.
REQ-036 Reset assertion mid-MEM SHALL drop mem_req and mem_we asynchronously.
REQ-037 The first mem_req SHALL appear in the first cycle after rst_n rises.

Structure
REQ-038 A shared package SHALL hold the opcode localparams, alu_op codes, the state enum, and the trap_cause and pc_src encodings.
REQ-039 Combinational decode (opcode class, alu_op, alu_src, legality) SHALL be a sub-module op_decode; the FSM and counter SHALL stay in multicycle_control.

Verification
REQ-040 The bench SHALL cover: reset, then instr=0x002081B3 (add) with mem_ready=1 at once -> FETCH, DECODE, EXECUTE, WRITEBACK; reg_write=1 in cycle 4, alu_op=0000, pc_write=1.
REQ-041 The bench SHALL cover: instr=0x40208133 (sub) -> alu_op=1000 and alu_src=0.
REQ-042 The bench SHALL cover: instr=0x0000A103 (lw) with mem_ready held low 3 cycles in MEM -> mem_req high 4 cycles, then WRITEBACK with mem_to_reg=1; total 8 cycles.
REQ-043 The bench SHALL cover: instr=0x00208463 (beq) with branch_taken=1 -> pc_write=1, pc_src=1 in EXECUTE, and no reg_write.
REQ-044 The bench SHALL cover: instr=0x0000007F (illegal) -> trap pulse in the cycle after DECODE, trap_cause=1, back in FETCH.
REQ-045 The bench SHALL cover: mem_ready held low in FETCH for 15 cycles -> trap with trap_cause=2.
REQ-046 The bench SHALL cover: with mem_ready held low, rst_n pulsed low mid-MEM -> mem_req=0 immediately and a restart in FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcodes, encodings and FSM state type
package multicycle_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_OP_ADD    = 4'b0000;
    localparam logic [3:0] ALU_OP_BRANCH = 4'b1000;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LUI,
        CLS_AUIPC,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-to-datapath/memory signal bundle
interface multicycle_control_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr;
    logic            mem_ready;
    logic            branch_taken;
    logic            mem_req;
    logic            mem_we;
    logic            ir_load;
    logic            pc_write;
    logic [1:0]      pc_src;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            trap;
    logic [1:0]      trap_cause;

    modport master (
        input  instr, mem_ready, branch_taken,
        output mem_req, mem_we, ir_load, pc_write, pc_src, alu_op,
               alu_src, mem_to_reg, reg_write, trap, trap_cause
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  mem_req, mem_we, ir_load, pc_write, pc_src, alu_op,
               alu_src, mem_to_reg, reg_write, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_control_op_decode.sv
// rtl/multicycle_control_op_decode.sv - opcode class, ALU op, operand select and legality
module op_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_bit30,
    output op_class_e  o_class,
    output logic [3:0] o_alu_op,
    output logic       o_alu_src,
    output logic       o_legal
);
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OPC_OP:     o_class = CLS_OP;
            OPC_OP_IMM: o_class = CLS_OP_IMM;
            OPC_LUI:    o_class = CLS_LUI;
            OPC_AUIPC:  o_class = CLS_AUIPC;
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_STORE:  o_class = CLS_STORE;
            OPC_BRANCH: o_class = CLS_BRANCH;
            OPC_JAL:    o_class = CLS_JAL;
            OPC_JALR:   o_class = CLS_JALR;
            default:    o_class = CLS_ILLEGAL;
        endcase
    end

    // Immediate forms only carry a real bit 30 for the right shifts (SRLI/SRAI).
    always_comb begin
        o_alu_op = ALU_OP_ADD;
        case (o_class)
            CLS_OP:     o_alu_op = {i_bit30, i_funct3};
            CLS_OP_IMM: o_alu_op = {(i_funct3 == 3'b101) & i_bit30, i_funct3};
            CLS_BRANCH: o_alu_op = ALU_OP_BRANCH;
            default:    o_alu_op = ALU_OP_ADD;
        endcase
    end

    assign o_alu_src = !((o_class == CLS_OP) || (o_class == CLS_BRANCH));
    assign o_legal   = (o_class != CLS_ILLEGAL);
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32 control FSM with bus-wait timeout trap
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int WAIT_LIMIT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    localparam int WAIT_W = ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_e            r_state, w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_cause;

    logic [XLEN-1:0] w_instr;
    logic            w_unused_instr_bits;
    op_class_e       w_class;
    logic [3:0]      w_alu_op;
    logic            w_alu_src, w_legal;
    logic            w_mem_req, w_mem_we, w_ir_load, w_pc_write;
    logic            w_mem_to_reg, w_reg_write, w_trap, w_set_cause;
    logic [1:0]      w_pc_src, w_cause;
    logic            w_at_limit, w_count;

    assign w_instr             = bus.instr;
    assign w_unused_instr_bits = ^{w_instr[XLEN-1:31], w_instr[29:15], w_instr[11:7]};

    op_decode u_op_decode (
        .i_opcode  (w_instr[6:0]),
        .i_funct3  (w_instr[14:12]),
        .i_bit30   (w_instr[30]),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_alu_src (w_alu_src),
        .o_legal   (w_legal)
    );

    // A ready on the cycle the counter sits at the limit still wins over the timeout.
    assign w_at_limit = (r_wait == WAIT_MAX) && !bus.mem_ready;
    assign w_count    = ((r_state == ST_FETCH) || (r_state == ST_MEM))
                        && !bus.mem_ready && (w_next == r_state);

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_load    = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_SRC_PLUS4;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_trap       = 1'b0;
        w_set_cause  = 1'b0;
        w_cause      = CAUSE_NONE;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = ST_DECODE;
                end else if (w_at_limit) begin
                    w_next      = ST_TRAP;
                    w_set_cause = 1'b1;
                    w_cause     = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (w_legal) begin
                    w_next = ST_EXECUTE;
                end else begin
                    w_next      = ST_TRAP;
                    w_set_cause = 1'b1;
                    w_cause     = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    CLS_BRANCH: begin
                        w_pc_write = bus.branch_taken;
                        w_pc_src   = PC_SRC_TARGET;
                        w_next     = ST_FETCH;
                    end
                    CLS_JAL: begin
                        w_pc_src = PC_SRC_TARGET;
                        w_next   = ST_WRITEBACK;
                    end
                    CLS_JALR: begin
                        w_pc_src = PC_SRC_JALR;
                        w_next   = ST_WRITEBACK;
                    end
                    default: w_next = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_class == CLS_STORE);
                if (bus.mem_ready) begin
                    if (w_class == CLS_STORE) begin
                        w_pc_write = 1'b1;
                        w_next     = ST_FETCH;
                    end else begin
                        w_next = ST_WRITEBACK;
                    end
                end else if (w_at_limit) begin
                    w_next      = ST_TRAP;
                    w_set_cause = 1'b1;
                    w_cause     = CAUSE_TIMEOUT;
                end
            end
            ST_WRITEBACK: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (w_class == CLS_LOAD);
                w_pc_write   = 1'b1;
                w_pc_src     = (w_class == CLS_JAL)  ? PC_SRC_TARGET :
                               (w_class == CLS_JALR) ? PC_SRC_JALR   : PC_SRC_PLUS4;
                w_next       = ST_FETCH;
            end
            ST_TRAP: begin
                w_trap = 1'b1;
                w_next = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_wait  <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_wait  <= w_count ? r_wait + 1'b1 : '0;
            if (w_set_cause) begin
                r_cause <= w_cause;
            end
        end
    end

    // Strobes are gated by rst_n so they fall the moment reset asserts, not at the next edge.
    assign bus.mem_req    = rst_n & w_mem_req;
    assign bus.mem_we     = rst_n & w_mem_we;
    assign bus.ir_load    = rst_n & w_ir_load;
    assign bus.pc_write   = rst_n & w_pc_write;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_op     = w_alu_op;
    assign bus.alu_src    = w_alu_src;
    assign bus.mem_to_reg = rst_n & w_mem_to_reg;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.trap       = rst_n & w_trap;
    assign bus.trap_cause = r_cause;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table/scoreboard bench for multicycle_control
module tb_multicycle_control;
    localparam int WAIT_LIMIT = 15;
    localparam int NV         = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.XLEN(32)) bus ();
    multicycle_control #(.XLEN(32), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        bt;
        int          mem_wait;
        bit          is_mem;
        int          cycles;
        int          rw;
        int          m2r;
        int          pcw;
        int          pcw_src;
        int          we;
        int          memreq;
        int          alu_op;
        int          alu_src;
        int          exec_src;
        int          traps;
    } vec_t;

    vec_t vecs[NV];
    vec_t sb[$];
    int   compared = 0;
    int   failed   = 0;

    task automatic check(input string what, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", what, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic [31:0] i, logic bt, int mw, bit mem,
                                int cyc, int rw, int m2r, int pcw, int psrc, int we,
                                int mrq, int aop, int asrc, int esrc, int trp);
        vec_t v;
        v.name = n; v.instr = i; v.bt = bt; v.mem_wait = mw; v.is_mem = mem;
        v.cycles = cyc; v.rw = rw; v.m2r = m2r; v.pcw = pcw; v.pcw_src = psrc;
        v.we = we; v.memreq = mrq; v.alu_op = aop; v.alu_src = asrc;
        v.exec_src = esrc; v.traps = trp;
        return v;
    endfunction

    task automatic fill_table();
        //           name     instr         bt  mw mem cyc rw m2r pcw psrc we mrq aop      asrc esrc trp
        vecs[0]  = mk("add",   32'h002081B3, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        vecs[1]  = mk("sub",   32'h40208133, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b1000, 0, 0, 0);
        vecs[2]  = mk("addi",  32'hFFF08093, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        vecs[3]  = mk("srai",  32'h4030D093, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b1101, 1, 0, 0);
        vecs[4]  = mk("lw_w3", 32'h0000A103, 0, 3, 1, 8, 1, 1, 1, 0, 0, 4, 4'b0000, 1, 0, 0);
        vecs[5]  = mk("sw",    32'h0020A023, 0, 0, 1, 4, 0, 0, 1, 0, 1, 1, 4'b0000, 1, 0, 0);
        vecs[6]  = mk("beq_t", 32'h00208463, 1, 0, 0, 3, 0, 0, 1, 1, 0, 0, 4'b1000, 0, 1, 0);
        vecs[7]  = mk("beq_n", 32'h00208463, 0, 0, 0, 3, 0, 0, 0, 3, 0, 0, 4'b1000, 0, 1, 0);
        vecs[8]  = mk("jal",   32'h008000EF, 0, 0, 0, 4, 1, 0, 1, 1, 0, 0, 4'b0000, 1, 1, 0);
        vecs[9]  = mk("jalr",  32'h000080E7, 0, 0, 0, 4, 1, 0, 1, 2, 0, 0, 4'b0000, 1, 2, 0);
        vecs[10] = mk("lui",   32'h123450B7, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        vecs[11] = mk("illeg", 32'h0000007F, 0, 0, 0, 3, 0, 0, 0, 3, 0, 0, 4'b0000, 1, 0, 1);
        vecs[12] = mk("lw_w0", 32'h0000A103, 0, 0, 1, 5, 1, 1, 1, 0, 0, 1, 4'b0000, 1, 0, 0);
        vecs[13] = mk("auipc", 32'h00000097, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        @(negedge clk);
        check("rst.mem_req", bus.mem_req, 0);
        check("rst.ir_load", bus.ir_load, 0);
        check("rst.pc_write", bus.pc_write, 0);
        check("rst.reg_write", bus.reg_write, 0);
        check("rst.trap", bus.trap, 0);
        check("rst.trap_cause", bus.trap_cause, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_ready = rdy;
        #1;
        check("rst.first_mem_req", bus.mem_req, 1);
    endtask

    // Each instruction's window runs from its own ir_load cycle to the next ir_load.
    task automatic run_table();
        vec_t cur, e;
        bit   open = 0, loaded, mem_done = 0;
        int   idx = 0, wcyc = 0, mem_lows = 0, guard = 0;
        int   o_rw, o_m2r, o_pcw, o_src, o_we, o_mrq, o_aop, o_asrc, o_esrc, o_trp, o_cause;
        while (1) begin
            bus.mem_ready = 1'b1;
            if (open && cur.is_mem && !mem_done && bus.mem_req && wcyc > 0) begin
                if (mem_lows < cur.mem_wait) begin
                    bus.mem_ready = 1'b0;
                    mem_lows++;
                end else begin
                    mem_done = 1;
                end
            end
            bus.branch_taken = open ? cur.bt : 1'b0;
            @(negedge clk);
            loaded = 0;
            if (bus.ir_load) begin
                if (open) begin
                    e = sb.pop_front();
                    check({e.name, ".cycles"}, wcyc, e.cycles);
                    check({e.name, ".reg_write"}, o_rw, e.rw);
                    check({e.name, ".mem_to_reg"}, o_m2r, e.m2r);
                    check({e.name, ".pc_write"}, o_pcw, e.pcw);
                    check({e.name, ".pcw_src"}, o_src, e.pcw_src);
                    check({e.name, ".mem_we"}, o_we, e.we);
                    check({e.name, ".mem_req"}, o_mrq, e.memreq);
                    check({e.name, ".alu_op"}, o_aop, e.alu_op);
                    check({e.name, ".alu_src"}, o_asrc, e.alu_src);
                    check({e.name, ".exec_src"}, o_esrc, e.exec_src);
                    check({e.name, ".trap"}, o_trp, e.traps);
                    if (e.traps > 0) check({e.name, ".cause"}, o_cause, 1);
                    open = 0;
                end
                if (idx == NV) break;
                cur = vecs[idx];
                idx++;
                sb.push_back(cur);
                open = 1; loaded = 1; wcyc = 0; mem_lows = 0; mem_done = 0;
                o_rw = 0; o_m2r = 0; o_pcw = 0; o_src = 3; o_we = 0; o_mrq = 0;
                o_aop = -1; o_asrc = -1; o_esrc = -1; o_trp = 0; o_cause = -1;
            end
            if (open) begin
                if (bus.reg_write) begin o_rw++; o_m2r = bus.mem_to_reg; end
                if (bus.pc_write) begin o_pcw++; o_src = bus.pc_src; end
                if (bus.mem_we) o_we++;
                if (bus.mem_req && wcyc > 0) o_mrq++;
                if (bus.trap) begin o_trp++; o_cause = bus.trap_cause; end
                if (wcyc == 2) begin
                    o_aop = bus.alu_op; o_asrc = bus.alu_src; o_esrc = bus.pc_src;
                end
                wcyc++;
                if (wcyc > 40) begin
                    check({cur.name, ".window_timeout"}, wcyc, cur.cycles);
                    break;
                end
            end
            guard++;
            if (guard > 1000) begin
                check("table.guard", guard, 0);
                break;
            end
            @(posedge clk); #1;
            if (loaded) bus.instr = cur.instr;
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.instr = 32'h0;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        fill_table();

        do_reset(1'b0);
        run_table();

        // Ready stays low in FETCH: counter values 0..WAIT_LIMIT all request, then TRAP.
        do_reset(1'b0);
        n = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.trap) begin
                seen = 1;
                check("timeout.cause", bus.trap_cause, 2);
                check("timeout.pc_write", bus.pc_write, 0);
                check("timeout.mem_req_in_trap", bus.mem_req, 0);
            end else if (bus.mem_req) begin
                n++;
            end
            @(posedge clk); #1;
        end
        check("timeout.seen", seen, 1);
        check("timeout.fetch_cycles", n, WAIT_LIMIT + 1);
        @(negedge clk);
        check("timeout.back_in_fetch", bus.mem_req, 1);
        check("timeout.trap_single", bus.trap, 0);
        check("timeout.cause_held", bus.trap_cause, 2);

        // Ready arrives exactly when the counter sits at WAIT_LIMIT.
        do_reset(1'b0);
        n = 0;
        for (int c = 0; c < WAIT_LIMIT; c++) begin
            @(negedge clk);
            if (bus.mem_req && !bus.trap) n++;
            @(posedge clk); #1;
        end
        check("limit.low_cycles", n, WAIT_LIMIT);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("limit.ir_load", bus.ir_load, 1);
        check("limit.no_trap", bus.trap, 0);
        @(posedge clk); #1;
        bus.instr = 32'h002081B3;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("limit.decode_no_trap", bus.trap, 0);
        check("limit.decode_no_req", bus.mem_req, 0);

        // Asynchronous reset in the middle of a stalled store.
        do_reset(1'b1);
        @(negedge clk);
        check("midmem.fetch_ir_load", bus.ir_load, 1);
        @(posedge clk); #1;
        bus.instr = 32'h0020A023;
        bus.mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("midmem.mem_req", bus.mem_req, 1);
        check("midmem.mem_we", bus.mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem.async_mem_req", bus.mem_req, 0);
        check("midmem.async_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("midmem.restart_req", bus.mem_req, 1);
        check("midmem.restart_we", bus.mem_we, 0);
        @(negedge clk);
        check("midmem.restart_ir_load", bus.ir_load, 1);
        check("midmem.cause_cleared", bus.trap_cause, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1);
    end
endmodule
